// File: rtl/voice_scheduler.sv
// Polyphonic voice scheduler: accepts note-on/off commands, picks a voice by
// retrigger / free / oldest priority, and runs a linear attack/release volume
// envelope per voice, stepped by a divided tick.

// One voice: frequency, target, envelope volume and saturating age.
module voice_env #(
    parameter int VOLUME_BITS   = 4,
    parameter int FREQ_RES_BITS = 16,
    parameter int AGE_BITS      = 8
) (
    input  logic                     mclk,
    input  logic                     rst,
    input  logic                     i_tick,
    input  logic                     i_note_on,
    input  logic                     i_age_inc,
    input  logic                     i_note_off,
    input  logic [FREQ_RES_BITS-1:0] i_cmd_freq,
    input  logic [VOLUME_BITS-1:0]   i_cmd_vol,
    output logic [FREQ_RES_BITS-1:0] o_freq,
    output logic [VOLUME_BITS-1:0]   o_vol,
    output logic                     o_active,
    output logic [AGE_BITS-1:0]      o_age
);
    typedef enum logic [1:0] {E_OFF, E_ATTACK, E_SUSTAIN, E_RELEASE} env_t;

    env_t                     r_state;
    logic [FREQ_RES_BITS-1:0] r_freq;
    logic [VOLUME_BITS-1:0]   r_target;
    logic [VOLUME_BITS-1:0]   r_vol;
    logic [AGE_BITS-1:0]      r_age;

    // Envelope state, volume stepping and allocation bookkeeping.
    // A note-on commit overrides any tick step in the same cycle; a note-off
    // commit moves the voice to RELEASE without a step that cycle.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_state  <= E_OFF;
            r_freq   <= '0;
            r_target <= '0;
            r_vol    <= '0;
            r_age    <= '0;
        end else if (i_note_on) begin
            r_state  <= E_ATTACK;
            r_freq   <= i_cmd_freq;
            r_target <= i_cmd_vol;
            r_vol    <= '0;
            r_age    <= '0;
        end else begin
            if (i_age_inc && (r_state != E_OFF) && (r_age != '1))
                r_age <= r_age + AGE_BITS'(1);
            if (i_note_off && ((r_state == E_ATTACK) || (r_state == E_SUSTAIN)) &&
                (r_freq == i_cmd_freq)) begin
                r_state <= E_RELEASE;
            end else if (i_tick) begin
                case (r_state)
                    E_ATTACK: begin
                        if (r_vol < r_target) begin
                            r_vol <= r_vol + VOLUME_BITS'(1);
                            if ((r_vol + VOLUME_BITS'(1)) == r_target)
                                r_state <= E_SUSTAIN;
                        end else begin
                            r_state <= E_SUSTAIN;
                        end
                    end
                    E_RELEASE: begin
                        if (r_vol != '0) begin
                            r_vol <= r_vol - VOLUME_BITS'(1);
                            if (r_vol == VOLUME_BITS'(1))
                                r_state <= E_OFF;
                        end else begin
                            r_state <= E_OFF;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_freq   = r_freq;
    assign o_vol    = r_vol;
    assign o_active = (r_state != E_OFF);
    assign o_age    = r_age;
endmodule

module voice_scheduler #(
    parameter int N_VOICES      = 4,
    parameter int VOLUME_BITS   = 4,
    parameter int FREQ_RES_BITS = 16,
    parameter int RAMP_DIV      = 256,
    parameter int AGE_BITS      = 8
) (
    input  logic                              mclk,
    input  logic                              rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_on,
    input  logic [FREQ_RES_BITS-1:0]          cmd_freq,
    input  logic [VOLUME_BITS-1:0]            cmd_vol,
    output logic [N_VOICES*FREQ_RES_BITS-1:0] voice_freq,
    output logic [N_VOICES*VOLUME_BITS-1:0]   voice_vol,
    output logic [N_VOICES-1:0]               voice_active,
    output logic                              steal_pulse
);
    localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

    state_t r_state, w_state_nxt;
    logic   r_ready, r_steal;
    logic   w_ready_nxt, w_steal_nxt, w_commit;

    logic [CNT_W-1:0] r_tick_cnt;
    logic             w_tick;

    // latched command; note-on with zero volume is folded into note-off
    logic                     r_cmd_on;
    logic [FREQ_RES_BITS-1:0] r_cmd_freq;
    logic [VOLUME_BITS-1:0]   r_cmd_vol;

    // scan results
    logic [IDX_W-1:0]    r_scan_idx;
    logic                r_retrig_found, w_retrig_found_nxt;
    logic [IDX_W-1:0]    r_retrig_idx, w_retrig_idx_nxt;
    logic                r_off_found, w_off_found_nxt;
    logic [IDX_W-1:0]    r_off_idx, w_off_idx_nxt;
    logic [AGE_BITS-1:0] r_max_age, w_max_age_nxt;
    logic [IDX_W-1:0]    r_max_idx, w_max_idx_nxt;

    // per-voice views
    logic [N_VOICES-1:0][FREQ_RES_BITS-1:0] w_v_freq;
    logic [N_VOICES-1:0][VOLUME_BITS-1:0]   w_v_vol;
    logic [N_VOICES-1:0][AGE_BITS-1:0]      w_v_age;
    logic [N_VOICES-1:0]                    w_v_active;

    logic                     w_hs, w_last;
    logic [FREQ_RES_BITS-1:0] w_sel_freq;
    logic [AGE_BITS-1:0]      w_sel_age;
    logic                     w_sel_active;
    logic [IDX_W-1:0]         w_sel_voice;
    logic                     w_age_inc, w_note_off;

    assign w_hs   = cmd_valid && r_ready && (r_state == S_IDLE);
    assign w_last = (r_scan_idx == IDX_W'(N_VOICES - 1));
    assign w_tick = (r_tick_cnt == CNT_W'(RAMP_DIV - 1));

    // Free-running envelope divider.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst)
            r_tick_cnt <= '0;
        else if (w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end

    // Control FSM state register.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Control FSM next state: one scan cycle per voice, then a commit cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_hs) w_state_nxt = S_SCAN;
            S_SCAN:   if (w_last) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Control FSM outputs; ready and steal are precomputed so they leave registers.
    always_comb begin
        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_commit    = (r_state == S_COMMIT);
        w_steal_nxt = (r_state == S_SCAN) && w_last && r_cmd_on &&
                      !w_retrig_found_nxt && !w_off_found_nxt;
    end

    // Registered handshake and steal outputs.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_ready <= 1'b1;
            r_steal <= 1'b0;
        end else begin
            r_ready <= w_ready_nxt;
            r_steal <= w_steal_nxt;
        end
    end

    assign w_sel_freq   = w_v_freq[r_scan_idx];
    assign w_sel_age    = w_v_age[r_scan_idx];
    assign w_sel_active = w_v_active[r_scan_idx];

    // Fold the currently examined voice into the running candidates.
    // Strict compare on age keeps the lowest index on ties.
    always_comb begin
        w_retrig_found_nxt = r_retrig_found;
        w_retrig_idx_nxt   = r_retrig_idx;
        w_off_found_nxt    = r_off_found;
        w_off_idx_nxt      = r_off_idx;
        w_max_age_nxt      = r_max_age;
        w_max_idx_nxt      = r_max_idx;
        if (!r_retrig_found && w_sel_active && (w_sel_freq == r_cmd_freq)) begin
            w_retrig_found_nxt = 1'b1;
            w_retrig_idx_nxt   = r_scan_idx;
        end
        if (!r_off_found && !w_sel_active) begin
            w_off_found_nxt = 1'b1;
            w_off_idx_nxt   = r_scan_idx;
        end
        if (w_sel_age > r_max_age) begin
            w_max_age_nxt = w_sel_age;
            w_max_idx_nxt = r_scan_idx;
        end
    end

    // Command latch and scan bookkeeping.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_cmd_on       <= 1'b0;
            r_cmd_freq     <= '0;
            r_cmd_vol      <= '0;
            r_scan_idx     <= '0;
            r_retrig_found <= 1'b0;
            r_retrig_idx   <= '0;
            r_off_found    <= 1'b0;
            r_off_idx      <= '0;
            r_max_age      <= '0;
            r_max_idx      <= '0;
        end else if (w_hs) begin
            r_cmd_on       <= cmd_on && (cmd_vol != '0);
            r_cmd_freq     <= cmd_freq;
            r_cmd_vol      <= cmd_vol;
            r_scan_idx     <= '0;
            r_retrig_found <= 1'b0;
            r_retrig_idx   <= '0;
            r_off_found    <= 1'b0;
            r_off_idx      <= '0;
            r_max_age      <= '0;
            r_max_idx      <= '0;
        end else if (r_state == S_SCAN) begin
            r_scan_idx     <= r_scan_idx + IDX_W'(1);
            r_retrig_found <= w_retrig_found_nxt;
            r_retrig_idx   <= w_retrig_idx_nxt;
            r_off_found    <= w_off_found_nxt;
            r_off_idx      <= w_off_idx_nxt;
            r_max_age      <= w_max_age_nxt;
            r_max_idx      <= w_max_idx_nxt;
        end
    end

    // Commit decision: retrigger, else free voice, else oldest.
    always_comb begin
        if (r_retrig_found)
            w_sel_voice = r_retrig_idx;
        else if (r_off_found)
            w_sel_voice = r_off_idx;
        else
            w_sel_voice = r_max_idx;
        w_age_inc  = w_commit && r_cmd_on;
        w_note_off = w_commit && !r_cmd_on;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_VOICES; gi++) begin : g_voice
            voice_env #(
                .VOLUME_BITS  (VOLUME_BITS),
                .FREQ_RES_BITS(FREQ_RES_BITS),
                .AGE_BITS     (AGE_BITS)
            ) u_voice (
                .mclk      (mclk),
                .rst       (rst),
                .i_tick    (w_tick),
                .i_note_on (w_age_inc && (w_sel_voice == IDX_W'(gi))),
                .i_age_inc (w_age_inc),
                .i_note_off(w_note_off),
                .i_cmd_freq(r_cmd_freq),
                .i_cmd_vol (r_cmd_vol),
                .o_freq    (w_v_freq[gi]),
                .o_vol     (w_v_vol[gi]),
                .o_active  (w_v_active[gi]),
                .o_age     (w_v_age[gi])
            );
        end
    endgenerate

    assign cmd_ready    = r_ready;
    assign steal_pulse  = r_steal;
    assign voice_freq   = w_v_freq;
    assign voice_vol    = w_v_vol;
    assign voice_active = w_v_active;
endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with N_VOICES=4, RAMP_DIV=4.
// Timeline is tracked in posedges since reset release (cyc); envelope steps
// land on edges where cyc % 4 == 0.
module tb_voice_scheduler;
    localparam int NV = 4;
    localparam int VB = 4;
    localparam int FB = 16;

    logic             mclk, rst;
    logic             cmd_valid, cmd_ready, cmd_on;
    logic [FB-1:0]    cmd_freq;
    logic [VB-1:0]    cmd_vol;
    logic [NV*FB-1:0] voice_freq;
    logic [NV*VB-1:0] voice_vol;
    logic [NV-1:0]    voice_active;
    logic             steal_pulse;

    int cyc;
    int checks;
    int failures;

    voice_scheduler #(
        .N_VOICES(NV), .VOLUME_BITS(VB), .FREQ_RES_BITS(FB), .RAMP_DIV(4), .AGE_BITS(8)
    ) dut (
        .mclk(mclk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_on(cmd_on),
        .cmd_freq(cmd_freq), .cmd_vol(cmd_vol),
        .voice_freq(voice_freq), .voice_vol(voice_vol),
        .voice_active(voice_active), .steal_pulse(steal_pulse)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one posedge, then settle at the following negedge
    task automatic clk1();
        @(posedge mclk);
        cyc++;
        @(negedge mclk);
    endtask

    task automatic run_until(input int e);
        while (cyc < e) clk1();
    endtask

    // present a command for exactly one edge; returns with cyc = handshake edge
    task automatic send(input logic on, input logic [FB-1:0] f, input logic [VB-1:0] v);
        chk("ready_before_send", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_on    = on;
        cmd_freq  = f;
        cmd_vol   = v;
        clk1();
        cmd_valid = 1'b0;
    endtask

    function automatic logic [FB-1:0] vf(input int i);
        return voice_freq[i*FB +: FB];
    endfunction

    function automatic logic [VB-1:0] vv(input int i);
        return voice_vol[i*VB +: VB];
    endfunction

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_on = 1'b0; cmd_freq = '0; cmd_vol = '0;
        repeat (2) @(negedge mclk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_steal", steal_pulse, 0);
        chk("rst_active", voice_active, 0);
        chk("rst_freq", voice_freq, 0);
        chk("rst_vol", voice_vol, 0);
        rst = 1'b0; cyc = 0;

        // reset in the middle of a scan aborts the command
        send(1'b1, 16'd111, 4'd3);
        clk1();
        chk("scan_ready_low", cmd_ready, 0);
        rst = 1'b1;
        #1;
        chk("midscan_rst_ready", cmd_ready, 1);
        chk("midscan_rst_active", voice_active, 0);
        chk("midscan_rst_steal", steal_pulse, 0);
        @(negedge mclk);
        @(negedge mclk);
        rst = 1'b0; cyc = 0;
        run_until(8);
        chk("abort_active", voice_active, 0);
        chk("abort_freq", voice_freq, 0);
        chk("abort_ready", cmd_ready, 1);

        // allocation and latency: handshake edge 9, commit edge 14
        send(1'b1, 16'd100, 4'd3);
        chk("lat_ready_t1", cmd_ready, 0);
        run_until(13);
        chk("lat_ready_t5", cmd_ready, 0);
        chk("lat_no_steal", steal_pulse, 0);
        chk("lat_inactive_t5", voice_active, 0);
        run_until(14);
        chk("lat_ready_t6", cmd_ready, 1);
        chk("lat_freq0", vf(0), 100);
        chk("lat_active", voice_active, 4'b0001);
        chk("lat_vol0_start", vv(0), 0);
        run_until(16);
        chk("att_vol0_1", vv(0), 1);
        run_until(24);
        chk("att_vol0_3", vv(0), 3);
        run_until(28);
        chk("sus_vol0_3", vv(0), 3);

        // fill; commit of 300 lands on a tick edge (40)
        send(1'b1, 16'd200, 4'd3);
        run_until(34);
        send(1'b1, 16'd300, 4'd3);
        run_until(40);
        chk("tick_commit_vol2", vv(2), 0);
        chk("tick_commit_vol1_stepped", vv(1), 2);
        chk("fill_freq2", vf(2), 300);
        send(1'b1, 16'd400, 4'd3);
        run_until(46);
        chk("fill_active", voice_active, 4'b1111);
        chk("fill_freq3", vf(3), 400);

        // steal oldest (voice 0): pulse during commit cycle 51, commit edge 52
        send(1'b1, 16'd500, 4'd3);
        run_until(50);
        chk("steal_pre", steal_pulse, 0);
        run_until(51);
        chk("steal_pulse", steal_pulse, 1);
        run_until(52);
        chk("steal_post", steal_pulse, 0);
        chk("steal_freq0", vf(0), 500);
        chk("steal_vol0", vv(0), 0);
        chk("steal_vol2", vv(2), 3);
        chk("steal_vol3", vv(3), 2);
        chk("steal_active", voice_active, 4'b1111);

        // note-off of 200 (voice 1): commit edge 70, steps at 72/76/80
        run_until(64);
        chk("sus_vol0_after_steal", vv(0), 3);
        send(1'b0, 16'd200, 4'd0);
        run_until(70);
        chk("rel_vol1_start", vv(1), 3);
        chk("rel_active_start", voice_active, 4'b1111);
        run_until(72);
        chk("rel_vol1_2", vv(1), 2);
        run_until(79);
        chk("rel_vol1_1", vv(1), 1);
        chk("rel_still_active", voice_active, 4'b1111);
        run_until(80);
        chk("rel_vol1_0", vv(1), 0);
        chk("rel_off", voice_active, 4'b1101);
        chk("rel_freq_held", vf(1), 200);

        // unmatched note-off changes nothing
        send(1'b0, 16'd999, 4'd0);
        run_until(90);
        chk("off999_active", voice_active, 4'b1101);
        chk("off999_vol", voice_vol, 16'h3303);
        chk("off999_freq", voice_freq, 64'h0190_012C_00C8_01F4);

        // retrigger 300 beats the free voice 1; commit edge 96 is also a tick
        send(1'b1, 16'd300, 4'd5);
        run_until(95);
        chk("retrig1_no_steal", steal_pulse, 0);
        run_until(96);
        chk("retrig1_vol2", vv(2), 0);
        chk("retrig1_active", voice_active, 4'b1101);
        chk("retrig1_freq1_kept", vf(1), 200);
        // retrigger again during attack: commit edge 102
        send(1'b1, 16'd300, 4'd5);
        run_until(101);
        chk("retrig2_vol_before", vv(2), 1);
        chk("retrig2_no_steal", steal_pulse, 0);
        run_until(102);
        chk("retrig2_vol2", vv(2), 0);
        chk("retrig2_freq2", vf(2), 300);
        chk("retrig2_active", voice_active, 4'b1101);
        run_until(112);
        chk("retrig2_vol_3", vv(2), 3);
        run_until(120);
        chk("retrig2_vol_5", vv(2), 5);
        run_until(124);
        chk("retrig2_sustain", vv(2), 5);

        // on(700,2) takes free voice 1, then on(700,0) acts as note-off
        send(1'b1, 16'd700, 4'd2);
        run_until(136);
        chk("v700_vol", vv(1), 2);
        chk("v700_freq", vf(1), 700);
        chk("v700_active", voice_active, 4'b1111);
        send(1'b1, 16'd700, 4'd0);
        run_until(141);
        chk("vol0_no_steal", steal_pulse, 0);
        run_until(142);
        chk("vol0_active", voice_active, 4'b1111);
        chk("vol0_vol1_held", vv(1), 2);
        run_until(144);
        chk("vol0_rel_1", vv(1), 1);
        run_until(148);
        chk("vol0_rel_0", vv(1), 0);
        chk("vol0_off", voice_active, 4'b1101);
        chk("vol0_freq0_kept", vf(0), 500);

        // refill voice 1, then steal: voice 3 is now oldest
        send(1'b1, 16'd800, 4'd1);
        run_until(154);
        chk("refill_freq1", vf(1), 800);
        chk("refill_active", voice_active, 4'b1111);
        send(1'b1, 16'd900, 4'd1);
        run_until(159);
        chk("steal2_pulse", steal_pulse, 1);
        run_until(160);
        chk("steal2_freq3", vf(3), 900);
        chk("steal2_vol3", vv(3), 0);
        chk("steal2_freq0", vf(0), 500);
        chk("steal2_pulse_end", steal_pulse, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
